// File: rtl/argmax_classifier.sv
// argmax_classifier: final classification stage after the FC layer.
// On the rising edge of fc_done it snapshots ten signed class scores. It then
// scans them one per cycle and publishes the index and value of the largest.
// Ties resolve to the lower index.
// Optional feature macro: ARGMAX_MARGIN_EN adds runner-up index and margin outputs.
module argmax_classifier #(
  parameter int SCORE_WIDTH = 113
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fc_done,
  input  logic signed [SCORE_WIDTH-1:0] prob_0,
  input  logic signed [SCORE_WIDTH-1:0] prob_1,
  input  logic signed [SCORE_WIDTH-1:0] prob_2,
  input  logic signed [SCORE_WIDTH-1:0] prob_3,
  input  logic signed [SCORE_WIDTH-1:0] prob_4,
  input  logic signed [SCORE_WIDTH-1:0] prob_5,
  input  logic signed [SCORE_WIDTH-1:0] prob_6,
  input  logic signed [SCORE_WIDTH-1:0] prob_7,
  input  logic signed [SCORE_WIDTH-1:0] prob_8,
  input  logic signed [SCORE_WIDTH-1:0] prob_9,
  output logic                          busy,
  output logic                          result_valid,
  output logic                          result_strobe,
  output logic [3:0]                    class_id,
  output logic signed [SCORE_WIDTH-1:0] class_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [3:0]                    runner_id,
  output logic [SCORE_WIDTH-1:0]        margin
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                        state_q, state_d;
  logic                          fc_done_q;
  logic signed [SCORE_WIDTH-1:0] score_buf_q [10];
  logic signed [SCORE_WIDTH-1:0] score_buf_d [10];
  logic signed [SCORE_WIDTH-1:0] best_q, best_d;
  logic [3:0]                    best_id_q, best_id_d;
  logic [3:0]                    ptr_q, ptr_d;
  logic                          busy_q, busy_d;
  logic                          valid_q, valid_d;
  logic                          strobe_q, strobe_d;
  logic [3:0]                    class_id_q, class_id_d;
  logic signed [SCORE_WIDTH-1:0] class_score_q, class_score_d;
  logic                          start;
  logic signed [SCORE_WIDTH-1:0] cand;
  logic signed [SCORE_WIDTH-1:0] new_best;
  logic [3:0]                    new_best_id;
`ifdef ARGMAX_MARGIN_EN
  logic signed [SCORE_WIDTH-1:0] second_q, second_d;
  logic [3:0]                    second_id_q, second_id_d;
  logic [3:0]                    runner_id_q, runner_id_d;
  logic [SCORE_WIDTH-1:0]        margin_q, margin_d;
  logic signed [SCORE_WIDTH-1:0] new_second;
  logic [3:0]                    new_second_id;
  logic [SCORE_WIDTH:0]          diff;
  localparam logic signed [SCORE_WIDTH-1:0] MostNeg = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
`endif

  assign start = fc_done & ~fc_done_q;

  // State register; reset aborts any scan so no partial result can escape.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fc_done_q     <= 1'b0;
      for (int i = 0; i < 10; i++) score_buf_q[i] <= '0;
      best_q        <= '0;
      best_id_q     <= '0;
      ptr_q         <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      strobe_q      <= 1'b0;
      class_id_q    <= '0;
      class_score_q <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q      <= '0;
      second_id_q   <= '0;
      runner_id_q   <= '0;
      margin_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fc_done_q     <= fc_done;
      score_buf_q   <= score_buf_d;
      best_q        <= best_d;
      best_id_q     <= best_id_d;
      ptr_q         <= ptr_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      strobe_q      <= strobe_d;
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
`ifdef ARGMAX_MARGIN_EN
      second_q      <= second_d;
      second_id_q   <= second_id_d;
      runner_id_q   <= runner_id_d;
      margin_q      <= margin_d;
`endif
    end
  end

  // Capture on start in IDLE, one compare per cycle in SCAN, publish at ptr 9.
  always_comb begin
    state_d       = state_q;
    score_buf_d   = score_buf_q;
    best_d        = best_q;
    best_id_d     = best_id_q;
    ptr_d         = ptr_q;
    busy_d        = busy_q;
    valid_d       = valid_q;
    strobe_d      = 1'b0;
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    cand          = score_buf_q[ptr_q];
    new_best      = best_q;
    new_best_id   = best_id_q;
`ifdef ARGMAX_MARGIN_EN
    second_d      = second_q;
    second_id_d   = second_id_q;
    runner_id_d   = runner_id_q;
    margin_d      = margin_q;
    new_second    = second_q;
    new_second_id = second_id_q;
    diff          = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          score_buf_d[0] = prob_0;
          score_buf_d[1] = prob_1;
          score_buf_d[2] = prob_2;
          score_buf_d[3] = prob_3;
          score_buf_d[4] = prob_4;
          score_buf_d[5] = prob_5;
          score_buf_d[6] = prob_6;
          score_buf_d[7] = prob_7;
          score_buf_d[8] = prob_8;
          score_buf_d[9] = prob_9;
          best_d    = prob_0;
          best_id_d = 4'd0;
          ptr_d     = 4'd1;
          valid_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = SCAN;
`ifdef ARGMAX_MARGIN_EN
          second_d    = MostNeg;
          second_id_d = 4'd0;
`endif
        end
      end
      SCAN: begin
        if (cand > best_q) begin
          new_best    = cand;
          new_best_id = ptr_q;
`ifdef ARGMAX_MARGIN_EN
          new_second    = best_q;
          new_second_id = best_id_q;
        end else if (cand > second_q) begin
          new_second    = cand;
          new_second_id = ptr_q;
`endif
        end
        best_d    = new_best;
        best_id_d = new_best_id;
        ptr_d     = ptr_q + 4'd1;
`ifdef ARGMAX_MARGIN_EN
        second_d    = new_second;
        second_id_d = new_second_id;
`endif
        if (ptr_q == 4'd9) begin
          class_id_d    = new_best_id;
          class_score_d = new_best;
          valid_d       = 1'b1;
          strobe_d      = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
`ifdef ARGMAX_MARGIN_EN
          diff        = {new_best[SCORE_WIDTH-1], new_best} - {new_second[SCORE_WIDTH-1], new_second};
          runner_id_d = new_second_id;
          margin_d    = diff[SCORE_WIDTH] ? {SCORE_WIDTH{1'b1}} : diff[SCORE_WIDTH-1:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign result_valid  = valid_q;
  assign result_strobe = strobe_q;
  assign class_id      = class_id_q;
  assign class_score   = class_score_q;
`ifdef ARGMAX_MARGIN_EN
  assign runner_id     = runner_id_q;
  assign margin        = margin_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier with an expected-result scoreboard.
// Works with or without ARGMAX_MARGIN_EN defined.
module tb_argmax_classifier;

  localparam int W = 113;

  typedef struct {
    logic [3:0]          id;
    logic signed [W-1:0] score;
    logic [3:0]          rid;
    logic [W-1:0]        margin;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                fc_done;
  logic signed [W-1:0] prob [10];
  logic                busy;
  logic                result_valid;
  logic                result_strobe;
  logic [3:0]          class_id;
  logic signed [W-1:0] class_score;
`ifdef ARGMAX_MARGIN_EN
  logic [3:0]          runner_id;
  logic [W-1:0]        margin;
`endif

  exp_t sbQueue [$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   strobeCount = 0;

  localparam logic signed [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

  argmax_classifier #(.SCORE_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .fc_done(fc_done),
    .prob_0(prob[0]), .prob_1(prob[1]), .prob_2(prob[2]), .prob_3(prob[3]),
    .prob_4(prob[4]), .prob_5(prob[5]), .prob_6(prob[6]), .prob_7(prob[7]),
    .prob_8(prob[8]), .prob_9(prob[9]),
    .busy(busy), .result_valid(result_valid), .result_strobe(result_strobe),
    .class_id(class_id), .class_score(class_score)
`ifdef ARGMAX_MARGIN_EN
    , .runner_id(runner_id), .margin(margin)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report any mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference result for the scores currently on prob[].
  function automatic exp_t model();
    exp_t e;
    logic signed [W-1:0] best, second;
    logic [3:0] bid, sid;
    logic signed [127:0] bw, sw, d;
    logic [127:0] maxU;
    best = prob[0]; bid = 0; second = MinNeg; sid = 0;
    for (int i = 1; i < 10; i++) begin
      if (prob[i] > best) begin
        second = best; sid = bid; best = prob[i]; bid = 4'(i);
      end else if (prob[i] > second) begin
        second = prob[i]; sid = 4'(i);
      end
    end
    bw = 128'(best); sw = 128'(second);
    d = bw - sw;
    maxU = (128'd1 << W) - 128'd1;
    e.id = bid; e.score = best; e.rid = sid;
    e.margin = (d > $signed(maxU)) ? {W{1'b1}} : d[W-1:0];
    return e;
  endfunction

  // Scoreboard side: every strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && result_strobe) begin
      exp_t e;
      strobeCount++;
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedStrobe", 1, 0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("classId", class_id, e.id);
        checkOutput("classScore", class_score, e.score);
        checkOutput("validAtStrobe", result_valid, 1);
        checkOutput("busyAtStrobe", busy, 0);
`ifdef ARGMAX_MARGIN_EN
        checkOutput("runnerId", runner_id, e.rid);
        checkOutput("margin", margin, e.margin);
`endif
      end
    end
  end

  // Run one frame: raise fc_done, optionally disturb inputs after capture, hold the level.
  task automatic applyStimulus(input int holdCycles, input bit corrupt);
    int lat;
    int startCount;
    sbQueue.push_back(model());
    startCount = strobeCount;
    lat = 0;
    @(negedge clk);
    fc_done = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checkOutput("busyAfterCapture", busy, 1);
        checkOutput("validClearedAtCapture", result_valid, 0);
      end
      if (corrupt && i == 3) begin
        for (int k = 0; k < 10; k++) prob[k] = MinNeg;
        prob[9] = MaxPos;
      end
      if (result_strobe) begin
        lat = i;
        break;
      end
    end
    checkOutput("strobeLatency", lat, 10);
    @(negedge clk);
    checkOutput("strobeOneCycle", result_strobe, 0);
    checkOutput("validHeld", result_valid, 1);
    checkOutput("busyAfterDone", busy, 0);
    repeat (holdCycles) @(negedge clk);
    checkOutput("strobesPerFrame", strobeCount - startCount, 1);
    checkOutput("validAfterHold", result_valid, 1);
    fc_done = 1'b0;
    @(negedge clk);
  endtask

  // Check every output is at its reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "Busy"}, busy, 0);
    checkOutput({tag, "Valid"}, result_valid, 0);
    checkOutput({tag, "Strobe"}, result_strobe, 0);
    checkOutput({tag, "Id"}, class_id, 0);
    checkOutput({tag, "Score"}, class_score, 0);
`ifdef ARGMAX_MARGIN_EN
    checkOutput({tag, "RunnerId"}, runner_id, 0);
    checkOutput({tag, "Margin"}, margin, 0);
`endif
  endtask

  // Main sequence of directed and random frames.
  initial begin
    logic signed [W-1:0] negVals [10];
    rst = 1'b1;
    fc_done = 1'b0;
    for (int k = 0; k < 10; k++) prob[k] = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single peak at index 7.
    for (int k = 0; k < 10; k++) prob[k] = '0;
    prob[7] = 500;
    applyStimulus(2, 1'b0);

    // All negative, largest -2 at index 3.
    negVals = '{-10, -9, -8, -2, -7, -6, -5, -4, -3, -10};
    for (int k = 0; k < 10; k++) prob[k] = negVals[k];
    applyStimulus(0, 1'b0);

    // Tie between 2 and 5.
    for (int k = 0; k < 10; k++) prob[k] = 1;
    prob[2] = 900;
    prob[5] = 900;
    applyStimulus(0, 1'b0);

    // Inputs change after capture, fc_done held high for 50 cycles.
    for (int k = 0; k < 10; k++) prob[k] = 4'(k);
    prob[4] = 77;
    applyStimulus(50, 1'b1);

    // Reset at C+4 aborts the scan and clears published outputs.
    for (int k = 0; k < 10; k++) prob[k] = 5;
    prob[6] = 1000;
    @(negedge clk);
    fc_done = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    fc_done = 1'b0;
    #1;
    checkResetState("midScanReset");
    repeat (12) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetState("afterAbort");

    // Fresh scan after the abort.
    applyStimulus(0, 1'b0);

    // Extremes: saturating margin.
    for (int k = 0; k < 10; k++) prob[k] = MinNeg;
    prob[0] = MaxPos;
    applyStimulus(0, 1'b0);

    // Random frames, alternating wide values and a tiny range that forces ties.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 10; k++) begin
        if (f % 2 == 0) prob[k] = W'({$urandom, $urandom, $urandom, $urandom});
        else prob[k] = W'($signed($urandom_range(6, 0)) - 3);
      end
      applyStimulus(f, 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", sbQueue.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
